// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : imem_loader_pkg
// Brief  : Shared types and constants for the instruction-memory loader.
// Rev    : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_COUNT = 3'd2,
        ST_DATA  = 3'd3,
        ST_CKSUM = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module : imem_loader_if
// Brief  : Byte-stream input, imem write port and status of the loader.
// Rev    : 1.0  initial release
// ============================================================================
interface imem_loader_if #(
    parameter int N  = 32,
    parameter int AW = 8
);
    import imem_loader_pkg::*;

    logic          s_valid;
    byte_t         s_data;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [N-1:0]  mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic          core_rst_n;

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_waddr, mem_wdata, busy, done, err, core_rst_n
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_waddr, mem_wdata, busy, done, err, core_rst_n
    );

endinterface
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
// Module : imem_word_packer
// Brief  : Packs little-endian bytes into N-bit words; one-cycle word_valid.
// Rev    : 1.0  initial release
// ============================================================================
module imem_word_packer
    import imem_loader_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear_i,
    input  logic         byte_valid_i,
    input  byte_t        byte_i,
    output logic         word_last_o,
    output logic         word_valid_o,
    output logic [N-1:0] word_o
);

    localparam int BPW = N / 8;
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  sr_q, sr_d;
    logic [N-1:0]  word_q, word_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  w_shift;

    // New byte enters at the top so the first byte ends up in bits [7:0].
    assign w_shift     = N'({byte_i, sr_q} >> 8);
    assign word_last_o = byte_valid_i && (idx_q == IW'(BPW - 1));

    always_comb begin
        idx_d   = idx_q;
        sr_d    = sr_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clear_i) begin
            idx_d = '0;
            sr_d  = '0;
        end else if (byte_valid_i) begin
            sr_d = w_shift;
            if (word_last_o) begin
                idx_d   = '0;
                word_d  = w_shift;
                valid_d = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            sr_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid_o = valid_q;
    assign word_o       = word_q;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module : imem_loader
// Brief  : Framed byte stream to imem writer; holds the core in reset until done.
// Config : IMEM_LOADER_CKSUM_EN adds a trailing XOR checksum byte and ERROR state.
// Rev    : 1.0  initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    imem_loader_if.slave bus
);

    localparam int WCW = ((AW > 8) ? AW : 8) + 1;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [AW-1:0]  waddr_q, waddr_d;
    logic [WCW-1:0] words_q, words_d;
    logic           ready_q;

    logic           w_accept;
    logic           w_sync;
    logic           w_frame_start;
    logic           w_data_byte;
    logic           w_word_last;
    logic           w_word_valid;
    logic [N-1:0]   w_word;

    assign w_accept    = bus.s_valid && ready_q;
    assign w_sync      = w_accept && (bus.s_data == SYNC_BYTE);
    assign w_data_byte = w_accept && (state_q == ST_DATA);

    imem_word_packer #(.N(N)) u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (w_frame_start),
        .byte_valid_i (w_data_byte),
        .byte_i       (bus.s_data),
        .word_last_o  (w_word_last),
        .word_valid_o (w_word_valid),
        .word_o       (w_word)
    );

`ifdef IMEM_LOADER_CKSUM_EN
    byte_t csum_q, csum_d;
    logic  w_cksum_ok;

    always_comb begin
        csum_d = csum_q;
        if (w_accept) begin
            case (state_q)
                ST_ADDR:          csum_d = bus.s_data;
                ST_COUNT, ST_DATA: csum_d = csum_q ^ bus.s_data;
                default:          csum_d = csum_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign w_cksum_ok = (bus.s_data == csum_q);
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        waddr_d       = waddr_q;
        words_d       = words_q;
        w_frame_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (w_sync) begin
                    state_d       = ST_ADDR;
                    w_frame_start = 1'b1;
                end
            end
            ST_ADDR: begin
                if (w_accept) begin
                    addr_d  = AW'(bus.s_data);
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (w_accept) begin
                    // A zero count means a full memory image.
                    words_d = (bus.s_data == 8'h00) ? (WCW'(1) << AW) : WCW'(bus.s_data);
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_word_last) begin
                    waddr_d = addr_q;
                    addr_d  = addr_q + AW'(1);
                    words_d = words_q - WCW'(1);
                    if (words_q == WCW'(1)) begin
`ifdef IMEM_LOADER_CKSUM_EN
                        state_d = ST_CKSUM;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (w_accept) begin
                    state_d = w_cksum_ok ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            waddr_q <= '0;
            words_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            words_q <= words_d;
            ready_q <= 1'b1;
        end
    end

    assign bus.s_ready    = ready_q;
    assign bus.mem_we     = w_word_valid;
    assign bus.mem_waddr  = waddr_q;
    assign bus.mem_wdata  = w_word;
    assign bus.busy       = (state_q == ST_ADDR) || (state_q == ST_COUNT) ||
                            (state_q == ST_DATA) || (state_q == ST_CKSUM);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.core_rst_n = (state_q == ST_DONE);
`ifdef IMEM_LOADER_CKSUM_EN
    assign bus.err        = (state_q == ST_ERROR);
`else
    assign bus.err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_imem_loader
// Brief  : Self-checking bench; expected writes derived from frame contents.
// Rev    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int N   = 32;
    localparam int AW  = 8;
    localparam int BPW = N / 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    logic [AW-1:0] obs_addr[$];
    logic [N-1:0]  obs_data[$];
    logic          obs_done[$];
    logic [7:0]    pay_q[$];

    imem_loader_if #(.N(N), .AW(AW)) bus ();

    imem_loader #(.N(N), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            obs_addr.push_back(bus.mem_waddr);
            obs_data.push_back(bus.mem_wdata);
            obs_done.push_back(bus.done);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"},    N'(bus.s_ready),    '0);
        chk({tag, "_mem_we"},     N'(bus.mem_we),     '0);
        chk({tag, "_mem_waddr"},  N'(bus.mem_waddr),  '0);
        chk({tag, "_mem_wdata"},  bus.mem_wdata,      '0);
        chk({tag, "_busy"},       N'(bus.busy),       '0);
        chk({tag, "_done"},       N'(bus.done),       '0);
        chk({tag, "_err"},        N'(bus.err),        '0);
        chk({tag, "_core_rst_n"}, N'(bus.core_rst_n), '0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        w = 0;
        while (bus.s_ready !== 1'b1 && w < 16) begin
            @(negedge clk);
            w++;
        end
        chk("s_ready_wait", N'(bus.s_ready), N'(1));
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic fill_random(input int nwords);
        pay_q.delete();
        for (int i = 0; i < nwords * BPW; i++) pay_q.push_back(8'($urandom));
    endtask

    // Sends one frame built from pay_q and checks writes and final status.
    task automatic run_frame(input string tag, input logic [7:0] st, input logic [7:0] cnt,
                             input bit corrupt, input bit gaps, input bit chk_sync);
        int            nw;
        logic [7:0]    ck;
        logic [N-1:0]  w;
        logic [AW-1:0] ea[$];
        logic [N-1:0]  ed[$];
        logic          e_done, e_err, e_last_done;
        int            nchk;
        nw = (cnt == 8'h00) ? 256 : int'(cnt);
        obs_addr.delete();
        obs_data.delete();
        obs_done.delete();
        send_byte(8'hA5);
        if (chk_sync) begin
            @(negedge clk);
            chk({tag, "_sync_core_rst_n"}, N'(bus.core_rst_n), '0);
            chk({tag, "_sync_done"},       N'(bus.done),       '0);
            chk({tag, "_sync_busy"},       N'(bus.busy),       N'(1));
        end
        send_byte(st);
        send_byte(cnt);
        ck = st ^ cnt;
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int k = 0; k < BPW; k++) begin
                w  = w | (N'(pay_q[i*BPW + k]) << (8 * k));
                ck = ck ^ pay_q[i*BPW + k];
                send_byte(pay_q[i*BPW + k]);
                if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            ea.push_back(AW'(int'(st) + i));
            ed.push_back(w);
        end
`ifdef IMEM_LOADER_CKSUM_EN
        send_byte(corrupt ? ~ck : ck);
        e_done = !corrupt; e_err = corrupt; e_last_done = 1'b0;
`else
        e_done = 1'b1; e_err = 1'b0; e_last_done = 1'b1;
`endif
        repeat (4) @(negedge clk);
        chk({tag, "_nwrites"}, N'(obs_addr.size()), N'(nw));
        nchk = (obs_addr.size() < nw) ? obs_addr.size() : nw;
        for (int i = 0; i < nchk; i++) begin
            chk({tag, "_waddr"}, N'(obs_addr[i]), N'(ea[i]));
            chk({tag, "_wdata"}, obs_data[i], ed[i]);
        end
        if (nchk > 0) chk({tag, "_done_at_last_we"}, N'(obs_done[nchk-1]), N'(e_last_done));
        chk({tag, "_hold_waddr"}, N'(bus.mem_waddr), N'(ea[nw-1]));
        chk({tag, "_hold_wdata"}, bus.mem_wdata, ed[nw-1]);
        chk({tag, "_mem_we_idle"}, N'(bus.mem_we), '0);
        chk({tag, "_done"}, N'(bus.done), N'(e_done));
        chk({tag, "_err"}, N'(bus.err), N'(e_err));
        chk({tag, "_core_rst_n"}, N'(bus.core_rst_n), N'(e_done));
        chk({tag, "_busy"}, N'(bus.busy), '0);
    endtask

    task automatic fill_test1;
        pay_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h97, 8'h31, 8'h00, 8'h00};
    endtask

    initial begin
        logic [7:0] b;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;

        // Reset state
        @(negedge clk);
        chk_all_zero("reset");
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", N'(bus.s_ready), N'(1));

        // Noise in IDLE is ignored, then the reference frame
        obs_addr.delete();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        @(negedge clk);
        chk("idle_noise_busy", N'(bus.busy), '0);
        chk("idle_noise_writes", N'(obs_addr.size()), '0);
        fill_test1();
        run_frame("t1", 8'h10, 8'h02, 1'b0, 1'b0, 1'b0);

        // Noise in DONE keeps done, then the same frame again
        obs_addr.delete();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b);
        end
        @(negedge clk);
        chk("done_noise_done", N'(bus.done), N'(1));
        chk("done_noise_writes", N'(obs_addr.size()), '0);
        fill_test1();
        run_frame("t2", 8'h10, 8'h02, 1'b0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CKSUM_EN
        fill_test1();
        run_frame("t4_bad", 8'h10, 8'h02, 1'b1, 1'b0, 1'b0);
        fill_test1();
        run_frame("t4_good", 8'h10, 8'h02, 1'b0, 1'b0, 1'b0);
`endif

        // Address wrap
        fill_random(2);
        run_frame("t3_wrap", 8'hFF, 8'h02, 1'b0, 1'b1, 1'b0);

        // Random frames with idle gaps
        for (int f = 0; f < 3; f++) begin
            int nw;
            nw = $urandom_range(1, 6);
            fill_random(nw);
            run_frame("rand", 8'($urandom), 8'(nw), 1'b0, 1'b1, 1'b0);
        end

        // Reset in the middle of a word
        obs_addr.delete();
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (3) @(negedge clk);
        chk("midreset_writes", N'(obs_addr.size()), '0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("midreset_ready", N'(bus.s_ready), N'(1));
        fill_random(3);
        run_frame("t5_after", 8'h40, 8'h03, 1'b0, 1'b0, 1'b0);

        // Resync from DONE, full 256-word image
        fill_random(256);
        run_frame("t6_full", 8'($urandom), 8'h00, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
